modrm_field_sequencer: RTL and testbench
========================================

Name: modrm_field_sequencer

Overview:
- Byte-serial successor to the combinational ModRM SIB/displacement detector.
- Accepts the ModRM byte and the bytes that follow it, one byte per cycle, over a valid/ready stream. Determines SIB and displacement presence and size for 32-bit or 16-bit addressing.
- Collects SIB and little-endian displacement bytes, then presents a complete, sign-extended addressing-field record with the consumed byte count.
- Sits in the decode stage between the instruction byte queue and the address-generation operand latch.

Parameters:
- ADDR16_EN, 1, 1 = 16-bit addressing supported via addr16 input; 0 = addr16 ignored, always 32-bit rules.
- DISP_W, 32, width of the sign-extended displacement output; legal range 32..64.

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- flush  input  1  synchronous abort of the current record
- in_valid  input  1  in_byte is valid
- in_byte  input  8  stream byte (ModRM, then SIB, then displacement LSB first)
- addr16  input  1  address-size mode; sampled only with the ModRM byte
- in_ready  output  1  block can accept a byte this cycle
- out_valid  output  1  record valid
- out_ready  input  1  consumer accepts record
- modrm  output  8  captured ModRM byte
- sib  output  8  captured SIB byte, 0 if absent
- sib_present  output  1  SIB byte was consumed
- disp_present  output  1  displacement was consumed
- disp_size  output  2  00 none, 01 disp8, 10 disp16, 11 disp32
- disp  output  DISP_W  sign-extended displacement, 0 if absent
- length  output  3  bytes consumed, 1..6

Behaviour:
- Reset (rst_n low at a clk edge):
  - State returns to S_MODRM.
  - All record outputs and out_valid are cleared to 0.
  - in_ready is combinationally 0 while rst_n is low.
  - Reset mid-record discards all partial data.
- States: S_MODRM, S_SIB, S_DISP, S_DONE. in_ready is 1 in S_MODRM, S_SIB and S_DISP, and 0 in S_DONE. A byte is accepted when in_valid and in_ready are both 1.
- S_MODRM accept:
  - Capture modrm and mode m16 = addr16 & ADDR16_EN. Set length = 1.
  - 32-bit mode:
    - mod=11: no SIB, no displacement.
    - mod!=11 and rm=100: SIB follows.
    - mod=00 and rm=101: disp32.
    - mod=01: disp8.
    - mod=10: disp32.
  - 16-bit mode: never SIB.
    - mod=00 and rm=110: disp16.
    - mod=01: disp8.
    - mod=10: disp16.
    - mod=11: none.
  - Next state: S_SIB if SIB follows, else S_DISP if a displacement is present, else S_DONE.
- S_SIB accept:
  - Capture sib; increment length.
  - If mod=00 and sib[2:0]=101, the displacement becomes disp32 (base override).
  - Next state: S_DISP if a displacement is present, else S_DONE.
- S_DISP:
  - A byte counter (0..3) places each accepted byte at bit position 8×count; length increments per byte.
  - After the final byte (1, 2 or 4 bytes), go to S_DONE.
  - disp is sign-extended from bit 7, 15 or 31 to DISP_W.
- S_DONE:
  - out_valid = 1; all record outputs are held stable until out_ready.
  - When out_valid and out_ready are both 1: return to S_MODRM, drop out_valid, and clear the byte counter.
  - Record outputs keep their values until the next ModRM is accepted.
  - One bubble cycle between records; no same-cycle accept.
- Latency: the record is valid the cycle after its last byte is accepted.
- in_valid low in any collecting state stalls without state change; partial fields are held.
- flush:
  - Has priority over any handshake in the same cycle.
  - Next state is S_MODRM; out_valid, length and the byte counter are cleared.
  - A byte presented with flush is dropped.
  - rst_n has priority over flush.
- addr16 changing after ModRM acceptance has no effect on the current record.

Test Plan:
- 32-bit mode, bytes 44 24 F0 → sib_present=1, sib=24, disp_size=01, disp=FFFFFFF0, length=3, out_valid one cycle after F0 is accepted.
- 32-bit mode, bytes 05 78 56 34 12 → sib_present=0, disp_size=11, disp=12345678, length=5. Then 04 25 EF BE AD DE (mod=00 with SIB base=101) → disp=DEADBEEF, length=6.
- addr16=1, bytes 06 34 12 → disp_size=10, disp=00001234, length=3. Then 46 80 → disp_size=01, disp=FFFFFF80, length=2. Then 04 with addr16=1 → no SIB, length=1. Repeat the last case with ADDR16_EN=0 → SIB expected.
- Byte C0 with out_ready held low for 3 cycles → out_valid=1, modrm=C0, length=1, in_ready=0, outputs stable. On out_ready=1, the next cycle has in_ready=1.
- in_valid gaps of 2 cycles between disp32 bytes → same result as back-to-back bytes. Random in_valid/out_ready stalls over 1000 records are checked against a reference model.
- flush asserted after SIB accepted in 44 24 … → returns to S_MODRM, no out_valid, next record 05 … decodes correctly. Repeat with rst_n low mid-disp → all outputs 0, in_ready 0 during reset.

Source files
------------

// File: rtl/modrm_field_sequencer_if.sv
// Byte stream in, addressing-field record out, for the ModRM field sequencer.
//
// Handshake rules (both channels): a transfer happens on the rising clk edge
// where valid and ready are both 1. The sender holds its payload stable while
// valid is 1 and ready is 0. The sequencer never makes out_valid depend on
// out_ready. in_ready is combinational from state and reset only, never from
// in_valid.
interface modrm_field_sequencer_if #(
   parameter int DISP_W = 32
);
   logic              in_valid;
   logic [7:0]        in_byte;
   logic              addr16;
   logic              in_ready;
   logic              out_valid;
   logic              out_ready;
   logic [7:0]        modrm;
   logic [7:0]        sib;
   logic              sib_present;
   logic              disp_present;
   logic [1:0]        disp_size;
   logic [DISP_W-1:0] disp;
   logic [2:0]        length;
   logic [1:0]        state_dbg;

   // Byte producer / record consumer side
   modport master (
      output in_valid, in_byte, addr16, out_ready,
      input  in_ready, out_valid, modrm, sib, sib_present, disp_present,
             disp_size, disp, length, state_dbg
   );

   // Sequencer side
   modport slave (
      input  in_valid, in_byte, addr16, out_ready,
      output in_ready, out_valid, modrm, sib, sib_present, disp_present,
             disp_size, disp, length, state_dbg
   );
endinterface

// File: rtl/modrm_field_sequencer.sv
// Byte-serial ModRM decoder: takes ModRM, optional SIB and a little-endian
// displacement one byte per cycle, then presents one sign-extended record.
module modrm_field_sequencer #(
   parameter bit ADDR16_EN = 1'b1,
   parameter int DISP_W    = 32
) (
   input logic                    clk,
   input logic                    rst_n,
   input logic                    flush,
   modrm_field_sequencer_if.slave bus
);

   typedef enum logic [1:0] {
      S_MODRM = 2'd0,
      S_SIB   = 2'd1,
      S_DISP  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  modrm_q, sib_q;
   logic        sib_present_q, disp_present_q;
   logic [1:0]  disp_size_q;
   logic [31:0] raw_q;
   logic [2:0]  length_q;
   logic [1:0]  cnt_q;

   logic        accept;
   logic        m16;
   logic        dec_sib;
   logic [1:0]  dec_size;
   logic [1:0]  sib_size;
   logic [1:0]  last_cnt;
   logic [1:0]  mod_in;
   logic [2:0]  rm_in;

   assign bus.in_ready = rst_n && (state_q != S_DONE);
   assign accept       = bus.in_valid && bus.in_ready;
   assign m16          = bus.addr16 & ADDR16_EN;
   assign mod_in       = bus.in_byte[7:6];
   assign rm_in        = bus.in_byte[2:0];

   // ModRM decode of the incoming byte; SIB base=101 with mod=00 forces disp32
   always_comb begin
      dec_sib  = 1'b0;
      dec_size = 2'b00;
      if (m16) begin
         if (mod_in == 2'b01)
            dec_size = 2'b01;
         else if (mod_in == 2'b10 || (mod_in == 2'b00 && rm_in == 3'b110))
            dec_size = 2'b10;
      end else begin
         dec_sib = (mod_in != 2'b11) && (rm_in == 3'b100);
         if (mod_in == 2'b01)
            dec_size = 2'b01;
         else if (mod_in == 2'b10 || (mod_in == 2'b00 && rm_in == 3'b101))
            dec_size = 2'b11;
      end
      sib_size = (modrm_q[7:6] == 2'b00 && rm_in == 3'b101) ? 2'b11 : disp_size_q;
      case (disp_size_q)
         2'b01:   last_cnt = 2'd0;
         2'b10:   last_cnt = 2'd1;
         default: last_cnt = 2'd3;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= S_MODRM;
      else        state_q <= state_d;
   end

   // Next-state logic; flush wins over any handshake
   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = S_MODRM;
      end else begin
         case (state_q)
            S_MODRM: if (accept)
               state_d = dec_sib ? S_SIB : ((dec_size != 2'b00) ? S_DISP : S_DONE);
            S_SIB:   if (accept)
               state_d = (sib_size != 2'b00) ? S_DISP : S_DONE;
            S_DISP:  if (accept && cnt_q == last_cnt)
               state_d = S_DONE;
            S_DONE:  if (bus.out_ready)
               state_d = S_MODRM;
            default: state_d = S_MODRM;
         endcase
      end
   end

   // Record capture; fields stay put until the next ModRM byte is accepted
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         modrm_q        <= '0;
         sib_q          <= '0;
         sib_present_q  <= 1'b0;
         disp_present_q <= 1'b0;
         disp_size_q    <= 2'b00;
         raw_q          <= '0;
         length_q       <= '0;
         cnt_q          <= '0;
      end else if (flush) begin
         length_q <= '0;
         cnt_q    <= '0;
      end else begin
         case (state_q)
            S_MODRM: if (accept) begin
               modrm_q        <= bus.in_byte;
               sib_q          <= '0;
               sib_present_q  <= 1'b0;
               disp_present_q <= (dec_size != 2'b00);
               disp_size_q    <= dec_size;
               raw_q          <= '0;
               length_q       <= 3'd1;
               cnt_q          <= '0;
            end
            S_SIB: if (accept) begin
               sib_q          <= bus.in_byte;
               sib_present_q  <= 1'b1;
               disp_size_q    <= sib_size;
               disp_present_q <= (sib_size != 2'b00);
               length_q       <= length_q + 3'd1;
            end
            S_DISP: if (accept) begin
               raw_q[{cnt_q, 3'b000} +: 8] <= bus.in_byte;
               cnt_q                       <= cnt_q + 2'd1;
               length_q                    <= length_q + 3'd1;
            end
            S_DONE: if (bus.out_ready) begin
               cnt_q <= '0;
            end
            default: ;
         endcase
      end
   end

   // Sign-extend the collected displacement from its natural width
   always_comb begin
      bus.disp = '0;
      case (disp_size_q)
         2'b01:   bus.disp = DISP_W'($signed(raw_q[7:0]));
         2'b10:   bus.disp = DISP_W'($signed(raw_q[15:0]));
         2'b11:   bus.disp = DISP_W'($signed(raw_q));
         default: bus.disp = '0;
      endcase
   end

   assign bus.out_valid    = (state_q == S_DONE);
   assign bus.modrm        = modrm_q;
   assign bus.sib          = sib_q;
   assign bus.sib_present  = sib_present_q;
   assign bus.disp_present = disp_present_q;
   assign bus.disp_size    = disp_size_q;
   assign bus.length       = length_q;
   assign bus.state_dbg    = state_q;

endmodule

// File: tb/tb_modrm_field_sequencer.sv
// Bench for modrm_field_sequencer: directed records, stall/flush/reset cases,
// then random records with random gaps and consumer stalls.
module tb_modrm_field_sequencer;
   localparam int DISP_W = 32;
   localparam int REC_W  = 8 + 8 + 1 + 1 + 2 + DISP_W + 3;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic flush = 1'b0;
   always #5 clk = ~clk;

   modrm_field_sequencer_if #(.DISP_W(DISP_W)) bus ();
   modrm_field_sequencer_if #(.DISP_W(DISP_W)) bus2 ();

   modrm_field_sequencer #(.ADDR16_EN(1'b1), .DISP_W(DISP_W)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus.slave)
   );

   modrm_field_sequencer #(.ADDR16_EN(1'b0), .DISP_W(DISP_W)) dut_no16 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus2.slave)
   );

   logic [REC_W-1:0] exp_q[$];
   int   checks   = 0;
   int   passed   = 0;
   logic rand_rdy = 1'b0;
   logic saw_acc  = 1'b0;

   task automatic check(input string tag, input logic [REC_W-1:0] obs, input logic [REC_W-1:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [REC_W-1:0] obs_rec();
      return {bus.modrm, bus.sib, bus.sib_present, bus.disp_present,
              bus.disp_size, bus.disp, bus.length};
   endfunction

   // Reference decode of a whole byte string into the expected record
   function automatic void model(input logic [7:0] b[6], input logic m16,
                                 output logic [REC_W-1:0] rec, output int n);
      logic [1:0]  mod;
      logic [2:0]  rm;
      logic        hs;
      int          nd, p;
      logic [31:0] raw;
      logic [31:0] d;
      logic [1:0]  dsz;
      mod = b[0][7:6];
      rm  = b[0][2:0];
      hs  = 1'b0;
      nd  = 0;
      if (m16) begin
         if (mod == 2'd1) nd = 1;
         else if (mod == 2'd2 || (mod == 2'd0 && rm == 3'd6)) nd = 2;
      end else begin
         hs = (mod != 2'd3) && (rm == 3'd4);
         if (mod == 2'd1) nd = 1;
         else if (mod == 2'd2 || (mod == 2'd0 && rm == 3'd5)) nd = 4;
         if (hs && mod == 2'd0 && b[1][2:0] == 3'd5) nd = 4;
      end
      p   = hs ? 2 : 1;
      raw = '0;
      for (int i = 0; i < nd; i++) raw = raw | (32'(b[p+i]) << (8 * i));
      case (nd)
         1:       begin d = {{24{raw[7]}}, raw[7:0]};   dsz = 2'b01; end
         2:       begin d = {{16{raw[15]}}, raw[15:0]}; dsz = 2'b10; end
         4:       begin d = raw;                        dsz = 2'b11; end
         default: begin d = '0;                         dsz = 2'b00; end
      endcase
      n   = p + nd;
      rec = {b[0], hs ? b[1] : 8'h00, hs, (nd != 0), dsz, d, 3'(n)};
   endfunction

   // One clock: sample at negedge (monitor + accept flag), drive after posedge
   task automatic tick();
      logic [REC_W-1:0] e;
      @(negedge clk);
      saw_acc = bus.in_valid && bus.in_ready && !flush && rst_n;
      if (bus.out_valid && bus.out_ready && !flush && rst_n) begin
         e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
         check("record", obs_rec(), e);
      end
      @(posedge clk);
      #1;
      if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic send_byte(input logic [7:0] b, input logic a16, input int gap);
      logic done;
      done = 1'b0;
      for (int g = 0; g < gap; g++) begin
         bus.in_valid = 1'b0;
         bus.in_byte  = 8'($urandom);
         tick();
      end
      bus.in_valid = 1'b1;
      bus.in_byte  = b;
      bus.addr16   = a16;
      for (int i = 0; i < 64 && !done; i++) begin
         tick();
         done = saw_acc;
      end
      bus.in_valid = 1'b0;
      bus.in_byte  = 8'($urandom);
      check("in_accept", done, 1);
   endtask

   // addr16 is flipped after the ModRM byte: it must not affect the record
   task automatic send_rec(input logic [7:0] b[6], input logic a16, input int gmin, input int gmax);
      logic [REC_W-1:0] e;
      int n;
      model(b, a16, e, n);
      exp_q.push_back(e);
      for (int i = 0; i < n; i++)
         send_byte(b[i], (i == 0) ? a16 : ~a16, $urandom_range(gmax, gmin));
      check("out_valid_latency", bus.out_valid, 1);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] bb[6];
      bus.in_valid   = 1'b0;
      bus.in_byte    = 8'h00;
      bus.addr16     = 1'b0;
      bus.out_ready  = 1'b1;
      bus2.in_valid  = 1'b0;
      bus2.in_byte   = 8'h00;
      bus2.addr16    = 1'b0;
      bus2.out_ready = 1'b1;
      rst_n = 1'b0;
      tick();
      tick();
      check("reset_in_ready", bus.in_ready, 0);
      check("reset_out_valid", bus.out_valid, 0);
      check("reset_record", obs_rec(), 0);
      rst_n = 1'b1;
      tick();
      check("idle_in_ready", bus.in_ready, 1);

      // 32-bit SIB + disp8
      bb = '{8'h44, 8'h24, 8'hF0, 8'h00, 8'h00, 8'h00};
      send_rec(bb, 1'b0, 0, 0);
      // 32-bit disp32, then SIB base override to disp32
      bb = '{8'h05, 8'h78, 8'h56, 8'h34, 8'h12, 8'h00};
      send_rec(bb, 1'b0, 0, 0);
      bb = '{8'h04, 8'h25, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
      send_rec(bb, 1'b0, 0, 0);
      // 16-bit forms
      bb = '{8'h06, 8'h34, 8'h12, 8'h00, 8'h00, 8'h00};
      send_rec(bb, 1'b1, 0, 0);
      bb = '{8'h46, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00};
      send_rec(bb, 1'b1, 0, 0);
      bb = '{8'h04, 8'h99, 8'h00, 8'h00, 8'h00, 8'h00};
      send_rec(bb, 1'b1, 0, 0);
      // disp32 with 2-cycle gaps between bytes
      bb = '{8'h85, 8'h01, 8'h80, 8'h00, 8'h80, 8'h00};
      send_rec(bb, 1'b0, 2, 2);

      // 16-bit support disabled: 04 with addr16=1 still takes a SIB
      for (int i = 0; i < 8 && bus.out_valid; i++) tick();
      bus2.in_valid = 1'b1;
      bus2.in_byte  = 8'h04;
      bus2.addr16   = 1'b1;
      tick();
      bus2.in_byte  = 8'h11;
      tick();
      bus2.in_valid = 1'b0;
      check("no16_out_valid", bus2.out_valid, 1);
      check("no16_sib_present", bus2.sib_present, 1);
      check("no16_sib", bus2.sib, 8'h11);
      check("no16_length", bus2.length, 2);
      check("no16_disp_size", bus2.disp_size, 0);

      // Consumer stall: record held, input blocked
      bus.out_ready = 1'b0;
      bb = '{8'hC0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      send_rec(bb, 1'b0, 0, 0);
      bus.in_valid = 1'b1;
      bus.in_byte  = 8'h05;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("hold_out_valid", bus.out_valid, 1);
         check("hold_in_ready", bus.in_ready, 0);
         check("hold_record", obs_rec(), exp_q[0]);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      check("bubble_out_valid", bus.out_valid, 0);
      check("bubble_in_ready", bus.in_ready, 1);

      // Flush after SIB, with a byte presented alongside the flush
      send_byte(8'h44, 1'b0, 0);
      send_byte(8'h24, 1'b1, 0);
      flush        = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_byte  = 8'hF0;
      tick();
      flush        = 1'b0;
      bus.in_valid = 1'b0;
      check("flush_state", bus.state_dbg, 0);
      check("flush_length", bus.length, 0);
      check("flush_in_ready", bus.in_ready, 1);
      tick();
      tick();
      check("flush_out_valid", bus.out_valid, 0);
      bb = '{8'h05, 8'h78, 8'h56, 8'h34, 8'h12, 8'h00};
      send_rec(bb, 1'b0, 0, 0);

      // Reset in the middle of a displacement
      send_byte(8'h05, 1'b0, 0);
      send_byte(8'h78, 1'b0, 0);
      send_byte(8'h56, 1'b0, 0);
      rst_n = 1'b0;
      #1;
      check("rst_mid_in_ready", bus.in_ready, 0);
      tick();
      check("rst_mid_in_ready_held", bus.in_ready, 0);
      check("rst_mid_out_valid", bus.out_valid, 0);
      check("rst_mid_record", obs_rec(), 0);
      rst_n = 1'b1;
      tick();
      bb = '{8'h46, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00};
      send_rec(bb, 1'b1, 0, 0);

      // Random records with random input gaps and consumer stalls
      rand_rdy = 1'b1;
      repeat (1000) begin
         for (int j = 0; j < 6; j++) bb[j] = 8'($urandom);
         send_rec(bb, 1'($urandom_range(0, 1)), 0, 2);
      end
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
      check("drain", exp_q.size(), 0);
      rand_rdy      = 1'b0;
      bus.out_ready = 1'b1;

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
